// File: rtl/display_bbox_scheduler_if.sv
// Detection stream handshake between the object detector and the bbox scheduler.
interface display_bbox_scheduler_if;
    logic [63:0] det_data;
    logic        det_valid;
    logic        det_null;
    logic        det_last;
    logic        det_ready;

    modport master (output det_data, det_valid, det_null, det_last, input det_ready);
    modport slave  (input det_data, det_valid, det_null, det_last, output det_ready);
endinterface

// File: rtl/display_bbox_scheduler.sv
// Collects one frame's detection boxes, then pushes exactly MAX_BBOX slot
// writes to the overlay drawing block during vertical blanking. Stale boxes
// are wiped with an all-empty load after STALE_FRAMES frames without a new set.
module display_bbox_scheduler #(
    parameter int FRAME_WIDTH  = 16,
    parameter int FRAME_HEIGHT = 9,
    parameter int MAX_BBOX     = 5,
    parameter int STALE_FRAMES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    display_bbox_scheduler_if.slave det,
    input  logic                    frame_sync,
    output logic [63:0]             bbox_data_out,
    output logic                    bbox_data_out_valid,
    output logic [7:0]              boxes_loaded,
    output logic                    overflow,
    output logic                    busy
);
    localparam int              IW          = $clog2(MAX_BBOX + 1);
    localparam logic [IW-1:0]   SLOTS       = IW'(MAX_BBOX);
    localparam logic [15:0]     X_MAX       = 16'(FRAME_WIDTH - 1);
    localparam logic [15:0]     Y_MAX       = 16'(FRAME_HEIGHT - 1);
    localparam logic [7:0]      STALE_LIMIT = 8'(STALE_FRAMES);
    localparam logic [63:0]     EMPTY_WORD  = '1;

    typedef enum logic [1:0] {ST_COLLECT, ST_PENDING, ST_LOAD} state_t;

    state_t        state;
    logic          clear_mode;
    logic [IW-1:0] idx;
    logic [IW-1:0] n;
    logic [IW-1:0] slot;
    logic [7:0]    stale_cnt;
    logic [63:0]   box_buf [MAX_BBOX];

    logic [15:0]   x0, y0, x1_c, y1_c;
    logic [63:0]   san_word;
    logic          san_ok;
    logic          accept;
    logic          store;
    logic          drop;
    logic [IW-1:0] idx_after;
    logic [7:0]    stale_next;
    logic [63:0]   next_word;

    assign det.det_ready = (state == ST_COLLECT);
    assign accept        = det.det_valid && (state == ST_COLLECT);

    // Clamp the bottom-right corner into the frame and reject inverted boxes.
    always_comb begin
        x0         = det.det_data[63:48];
        y0         = det.det_data[47:32];
        x1_c       = (det.det_data[31:16] > X_MAX) ? X_MAX : det.det_data[31:16];
        y1_c       = (det.det_data[15:0]  > Y_MAX) ? Y_MAX : det.det_data[15:0];
        san_word   = {x0, y0, x1_c, y1_c};
        san_ok     = !det.det_null && (x0 <= x1_c) && (y0 <= y1_c);
        store      = accept && san_ok && (idx < SLOTS);
        drop       = accept && san_ok && (idx == SLOTS);
        idx_after  = store ? idx + 1'b1 : idx;
        stale_next = (stale_cnt == 8'hFF) ? stale_cnt : stale_cnt + 8'd1;
    end

    // Word for the slot about to be written; a load entered from COLLECT is always a clear.
    always_comb begin
        if (state == ST_COLLECT || (state == ST_LOAD && clear_mode) || slot >= n) begin
            next_word = EMPTY_WORD;
        end else begin
            next_word = box_buf[slot];
        end
    end

    // Box storage for the set being collected.
    // NOTE: the buffer has no reset; n and idx gate every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (store) begin
            box_buf[idx] <= san_word;
        end
    end

    // Control FSM with registered write port and status outputs.
    // NOTE: all state here uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_COLLECT;
            clear_mode          <= 1'b0;
            idx                 <= '0;
            n                   <= '0;
            slot                <= '0;
            stale_cnt           <= 8'd0;
            boxes_loaded        <= 8'd0;
            overflow            <= 1'b0;
            busy                <= 1'b0;
            bbox_data_out_valid <= 1'b0;
            bbox_data_out       <= 64'd0;
        end else begin
            bbox_data_out_valid <= 1'b0;
            unique case (state)
                ST_COLLECT: begin
                    if (store) idx <= idx + 1'b1;
                    if (drop) overflow <= 1'b1;
                    if (accept && det.det_last) begin
                        // A completed set wins over a coincident frame_sync.
                        n     <= idx_after;
                        state <= ST_PENDING;
                    end else if (frame_sync) begin
                        stale_cnt <= stale_next;
                        if (stale_next >= STALE_LIMIT && boxes_loaded != 8'd0) begin
                            state               <= ST_LOAD;
                            clear_mode          <= 1'b1;
                            busy                <= 1'b1;
                            bbox_data_out_valid <= 1'b1;
                            bbox_data_out       <= next_word;
                            slot                <= IW'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (frame_sync) begin
                        state               <= ST_LOAD;
                        clear_mode          <= 1'b0;
                        busy                <= 1'b1;
                        bbox_data_out_valid <= 1'b1;
                        bbox_data_out       <= next_word;
                        slot                <= IW'(1);
                    end
                end
                ST_LOAD: begin
                    if (slot < SLOTS) begin
                        bbox_data_out_valid <= 1'b1;
                        bbox_data_out       <= next_word;
                        slot                <= slot + 1'b1;
                    end else begin
                        state     <= ST_COLLECT;
                        busy      <= 1'b0;
                        slot      <= '0;
                        stale_cnt <= 8'd0;
                        if (clear_mode) begin
                            boxes_loaded <= 8'd0;
                        end else begin
                            boxes_loaded <= 8'(n);
                            idx          <= '0;
                        end
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end
endmodule
